// File: rtl/vmicro16_uart_rx_apb.sv
// APB slave UART receiver: 8N1 deserialiser feeding a byte FIFO, with DATA/STATUS
// registers on a zero-wait-state APB port and an irq level while bytes are pending.
module vmicro16_uart_rx_apb #(
  parameter int BUS_WIDTH    = 16,
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] S_PADDR,
  input  logic                 S_PWRITE,
  input  logic                 S_PSELx,
  input  logic                 S_PENABLE,
  input  logic [BUS_WIDTH-1:0] S_PWDATA,
  output logic [BUS_WIDTH-1:0] S_PRDATA,
  output logic                 S_PREADY,
  input  logic                 rx_wire,
  output logic                 irq
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  // APB handshake: a transfer completes in the single cycle where PSELx and PENABLE
  // are both high; PREADY mirrors that cycle, so the slave never inserts wait states.

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_rx_meta;
  logic            r_rx_s;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW:0]     r_wp;
  logic [AW:0]     r_rp;
  logic            r_ovr;
  logic            r_ferr;

  logic            w_acc;
  logic [AW:0]     w_count;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_stop_tick;
  logic            w_push_req;
  logic            w_push;
  logic            w_stat_wr;
  logic            w_unused;

  assign w_acc       = S_PSELx & S_PENABLE;
  assign S_PREADY    = w_acc;
  assign w_count     = r_wp - r_rp;
  assign w_empty     = (r_wp == r_rp);
  assign w_full      = (w_count == (AW+1)'(FIFO_DEPTH));
  assign w_pop       = w_acc & ~S_PWRITE & (S_PADDR[1:0] == 2'd0) & ~w_empty;
  assign w_stat_wr   = w_acc & S_PWRITE & (S_PADDR[1:0] == 2'd1);
  assign w_stop_tick = (r_state == S_STOP) && (r_cnt == FULL_M1);
  assign w_push_req  = w_stop_tick & r_rx_s;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
  assign w_push      = w_push_req & (~w_full | w_pop);
  assign irq         = ~w_empty;
  assign w_unused    = ^{S_PADDR[BUS_WIDTH-1:2], S_PWDATA[BUS_WIDTH-1:4], S_PWDATA[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx_wire;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          r_bit <= '0;
          if (!r_rx_s) r_state <= S_START;
        end
        S_START: begin
          if (r_cnt == HALF_M1) begin
            r_cnt   <= '0;
            r_state <= r_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == FULL_M1) begin
            r_cnt   <= '0;
            r_shift <= {r_rx_s, r_shift[7:1]};
            r_bit   <= r_bit + 1'b1;
            if (r_bit == 3'd7) r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_cnt == FULL_M1) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= r_shift;
  end

  // Clears are applied first so a same-cycle set takes precedence.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_ovr  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      if (w_stat_wr && S_PWDATA[2]) r_ovr  <= 1'b0;
      if (w_stat_wr && S_PWDATA[3]) r_ferr <= 1'b0;
      if (w_push_req && w_full && !w_pop) r_ovr <= 1'b1;
      if (w_stop_tick && !r_rx_s) r_ferr <= 1'b1;
    end
  end

  always_comb begin
    S_PRDATA = '0;
    if (S_PSELx) begin
      case (S_PADDR[1:0])
        2'd0: if (!w_empty) S_PRDATA[7:0] = r_mem[r_rp[AW-1:0]];
        2'd1: S_PRDATA[3:0] = {r_ferr, r_ovr, w_full, ~w_empty};
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_vmicro16_uart_rx_apb.sv
// Bench for vmicro16_uart_rx_apb: serial frames in, APB reads out, checked against a
// reference FIFO queue and sticky-flag model.
module tb_vmicro16_uart_rx_apb;
  localparam int BW    = 16;
  localparam int CPB   = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [BW-1:0] paddr = '0;
  logic          pwrite = 1'b0;
  logic          psel = 1'b0;
  logic          penable = 1'b0;
  logic [BW-1:0] pwdata = '0;
  logic [BW-1:0] prdata;
  logic          pready;
  logic          rx = 1'b1;
  logic          irq;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  bit         m_ovr = 1'b0;
  bit         m_ferr = 1'b0;

  vmicro16_uart_rx_apb #(.BUS_WIDTH(BW), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .S_PADDR(paddr), .S_PWRITE(pwrite), .S_PSELx(psel), .S_PENABLE(penable),
    .S_PWDATA(pwdata), .S_PRDATA(prdata), .S_PREADY(pready),
    .rx_wire(rx), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] exp_status();
    logic [BW-1:0] s;
    s = '0;
    s[0] = (exp_q.size() != 0);
    s[1] = (exp_q.size() == DEPTH);
    s[2] = m_ovr;
    s[3] = m_ferr;
    return s;
  endfunction

  task automatic model_push(input logic [7:0] b);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else m_ovr = 1'b1;
  endtask

  task automatic apb_xfer(input logic wr, input logic [BW-1:0] addr,
                          input logic [BW-1:0] wdata, output logic [BW-1:0] rdata);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    #1 chk("pready_setup", {15'd0, pready}, 16'd0);
    @(negedge clk);
    penable = 1'b1;
    #1 rdata = prdata;
    chk("pready_acc", {15'd0, pready}, 16'd1);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    #1 chk("pready_idle", {15'd0, pready}, 16'd0);
    chk("prdata_unsel", prdata, 16'd0);
  endtask

  task automatic check_status(input string tag);
    logic [BW-1:0] d;
    apb_xfer(1'b0, 16'd1, 16'd0, d);
    chk(tag, d, exp_status());
    chk({tag, "_irq"}, {15'd0, irq}, {15'd0, exp_q.size() != 0});
  endtask

  task automatic read_data(input string tag);
    logic [BW-1:0] d;
    logic [BW-1:0] e;
    apb_xfer(1'b0, 16'd0, 16'd0, d);
    e = (exp_q.size() != 0) ? {8'd0, exp_q.pop_front()} : 16'd0;
    chk(tag, d, e);
  endtask

  task automatic write_status(input logic [BW-1:0] v);
    logic [BW-1:0] d;
    apb_xfer(1'b1, 16'd1, v, d);
    if (v[2]) m_ovr = 1'b0;
    if (v[3]) m_ferr = 1'b0;
  endtask

  // One 8N1 frame, CPB cycles per bit; optionally a DATA read whose access
  // phase lands on the stop-bit sampling edge.
  task automatic send_byte(input logic [7:0] b, input logic stop_ok, input bit pop_at_stop);
    logic [9:0]    frame;
    logic [BW-1:0] e;
    frame = {stop_ok, b, 1'b0};
    for (int c = 0; c < 10 * CPB; c++) begin
      @(negedge clk);
      rx = frame[c / CPB];
      if (pop_at_stop) begin
        if (c == 10 * CPB - 3) begin
          psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'd0;
        end else if (c == 10 * CPB - 2) begin
          penable = 1'b1;
          e = (exp_q.size() != 0) ? {8'd0, exp_q.pop_front()} : 16'd0;
          #1 chk("data_at_stop", prdata, e);
          chk("pready_at_stop", {15'd0, pready}, 16'd1);
        end else if (c == 10 * CPB - 1) begin
          psel = 1'b0; penable = 1'b0;
        end
      end
    end
    @(negedge clk);
    rx = 1'b1;
    if (stop_ok) model_push(b);
    else m_ferr = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    m_ovr = 1'b0;
    m_ferr = 1'b0;
  endtask

  initial begin
    logic [7:0] partial;
    do_reset();
    #1 chk("reset_irq", {15'd0, irq}, 16'd0);
    chk("reset_prdata", prdata, 16'd0);
    chk("reset_pready", {15'd0, pready}, 16'd0);
    check_status("reset_status");

    // single byte
    send_byte(8'hA5, 1'b1, 1'b0);
    #1 chk("a5_irq_after_stop", {15'd0, irq}, 16'd1);
    check_status("a5_status");
    read_data("a5_data");
    check_status("a5_status_after");

    // overflow
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1, 1'b0);
    check_status("ovr_status");
    for (int i = 0; i < 5; i++) read_data("ovr_data");
    check_status("ovr_status_drained");
    write_status(16'h0004);
    check_status("ovr_cleared");

    // framing error, then a good frame
    send_byte(8'h3C, 1'b0, 1'b0);
    check_status("ferr_status");
    send_byte(8'h7E, 1'b1, 1'b0);
    check_status("ferr_then_good");
    read_data("good_7e");
    write_status(16'h0008);
    check_status("ferr_cleared");

    // start-bit glitch
    @(negedge clk);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check_status("glitch_status");

    // full FIFO with a pop on the stop-sample edge
    for (int i = 1; i <= DEPTH; i++) send_byte(8'(8'h11 * i), 1'b1, 1'b0);
    check_status("full_status");
    send_byte(8'h99, 1'b1, 1'b1);
    check_status("pop_push_status");
    for (int i = 0; i < DEPTH; i++) read_data("pop_push_data");
    check_status("pop_push_drained");

    // reset in the middle of data bit 3
    partial = 8'hF0;
    for (int c = 0; c < 4 * CPB + CPB / 2; c++) begin
      @(negedge clk);
      rx = (c < CPB) ? 1'b0 : partial[(c / CPB) - 1];
    end
    do_reset();
    repeat (4) @(negedge clk);
    check_status("midreset_status");
    send_byte(8'h55, 1'b1, 1'b0);
    check_status("after_reset_status");
    read_data("after_reset_55");
    check_status("after_reset_empty");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
